// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - OV7670 capture sequencer writing RGB332 pixels into the frame buffer
//
// Oversamples the camera bus in the CLOCK domain, tracks frame and line
// boundaries, packs RGB565 byte pairs into RGB332 and issues frame buffer writes.
//
// Ports:
//   CLOCK, RESET         system clock, synchronous active-high reset
//   CAM_PCLK/HREF/VSYNC  camera timing, asynchronous, oversampled
//   CAM_DATA             camera byte
//   CAPTURE_MODE         0 = continuous, 1 = single-shot (sampled at frame end)
//   ARM                  start capture, honoured only when idle
//   W_EN/W_ADDR/W_DATA   frame buffer write port
//   BUSY                 capture sequencer not idle
//   FRAME_DONE           one-cycle pulse at end of a captured frame
//   FRAME_COUNT          completed frames, wrapping
//   LINE_ERR             sticky geometry error, cleared by RESET or ARM

module cam_capture_ctrl #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              CAM_PCLK,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [7:0]        CAM_DATA,
  input  logic              CAPTURE_MODE,
  input  logic              ARM,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_COUNT,
  output logic              LINE_ERR
);

  // x saturates at SCREEN_WIDTH, y at SCREEN_HEIGHT + 1
  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 2);
  localparam logic [XW-1:0]     X_END    = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]     Y_END    = YW'(SCREEN_HEIGHT);
  localparam logic [YW-1:0]     Y_SAT    = YW'(SCREEN_HEIGHT + 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FALL,
    ST_CAPTURE
  } state_t;

  // All four camera signals share the same pipeline depth so they stay aligned.
  logic       pclk_s1, pclk_s2, pclk_s3;
  logic       href_s1, href_s2, href_s3;
  logic       vsync_s1, vsync_s2, vsync_s3;
  logic [7:0] data_s1, data_s2;

  // Registered event stage: decoded edges plus the data/HREF aligned with them.
  logic       ev_pclk_rise, ev_href_fall, ev_vsync_rise, ev_vsync_fall;
  logic       ev_href;
  logic [7:0] ev_data;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] row_base;
  logic              byte_phase;
  logic [5:0]        hi_bits;   // R (d15:13) and G (d10:8) fields of the first byte

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3  <= 1'b0;
      href_s1  <= 1'b0; href_s2  <= 1'b0; href_s3  <= 1'b0;
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_s3 <= 1'b0;
      data_s1  <= 8'd0; data_s2  <= 8'd0;
      ev_pclk_rise  <= 1'b0;
      ev_href_fall  <= 1'b0;
      ev_vsync_rise <= 1'b0;
      ev_vsync_fall <= 1'b0;
      ev_href       <= 1'b0;
      ev_data       <= 8'd0;
    end else begin
      pclk_s1  <= CAM_PCLK;  pclk_s2  <= pclk_s1;  pclk_s3  <= pclk_s2;
      href_s1  <= CAM_HREF;  href_s2  <= href_s1;  href_s3  <= href_s2;
      vsync_s1 <= CAM_VSYNC; vsync_s2 <= vsync_s1; vsync_s3 <= vsync_s2;
      data_s1  <= CAM_DATA;  data_s2  <= data_s1;
      ev_pclk_rise  <= pclk_s2 & ~pclk_s3;
      ev_href_fall  <= ~href_s2 & href_s3;
      ev_vsync_rise <= vsync_s2 & ~vsync_s3;
      ev_vsync_fall <= ~vsync_s2 & vsync_s3;
      ev_href       <= href_s2;
      ev_data       <= data_s2;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      byte_phase  <= 1'b0;
      hi_bits     <= 6'd0;
      W_EN        <= 1'b0;
      W_ADDR      <= '0;
      W_DATA      <= 8'd0;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
      FRAME_COUNT <= 8'd0;
      LINE_ERR    <= 1'b0;
    end else begin
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ARM) begin
            state    <= ST_WAIT_FALL;
            BUSY     <= 1'b1;
            LINE_ERR <= 1'b0;
          end
        end

        // Only a falling VSYNC starts capture, so a partial frame is never stored.
        ST_WAIT_FALL: begin
          if (ev_vsync_fall) begin
            state      <= ST_CAPTURE;
            x          <= '0;
            y          <= '0;
            row_base   <= '0;
            byte_phase <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          // Priority: frame end, then line end, then pixel byte.
          if (ev_vsync_rise) begin
            FRAME_DONE  <= 1'b1;
            FRAME_COUNT <= FRAME_COUNT + 8'd1;
            if (y != Y_END) LINE_ERR <= 1'b1;
            if (CAPTURE_MODE) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= ST_WAIT_FALL;
            end
          end else if (ev_href_fall) begin
            x          <= '0;
            byte_phase <= 1'b0;   // a dangling first byte is discarded
            if (x != X_END || byte_phase) LINE_ERR <= 1'b1;
            if (y == Y_SAT) begin
              LINE_ERR <= 1'b1;
            end else begin
              y        <= y + 1'b1;
              row_base <= row_base + ROW_STEP;
            end
          end else if (ev_pclk_rise && ev_href) begin
            if (!byte_phase) begin
              hi_bits    <= {ev_data[7:5], ev_data[2:0]};
              byte_phase <= 1'b1;
            end else begin
              byte_phase <= 1'b0;
              if (x < X_END && y < Y_END) begin
                W_EN   <= 1'b1;
                W_ADDR <= row_base + ADDR_W'(x);
                W_DATA <= {hi_bits, ev_data[4:3]};
                x      <= x + 1'b1;
              end else begin
                LINE_ERR <= 1'b1;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - scoreboard testbench for cam_capture_ctrl

module tb_cam_capture_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 15;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          CAM_PCLK = 1'b0;
  logic          CAM_HREF = 1'b0;
  logic          CAM_VSYNC = 1'b1;
  logic [7:0]    CAM_DATA = 8'd0;
  logic          CAPTURE_MODE = 1'b1;
  logic          ARM = 1'b0;
  logic          W_EN;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          BUSY;
  logic          FRAME_DONE;
  logic [7:0]    FRAME_COUNT;
  logic          LINE_ERR;

  cam_capture_ctrl #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .ADDR_W       (AW)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .CAM_PCLK    (CAM_PCLK),
    .CAM_HREF    (CAM_HREF),
    .CAM_VSYNC   (CAM_VSYNC),
    .CAM_DATA    (CAM_DATA),
    .CAPTURE_MODE(CAPTURE_MODE),
    .ARM         (ARM),
    .W_EN        (W_EN),
    .W_ADDR      (W_ADDR),
    .W_DATA      (W_DATA),
    .BUSY        (BUSY),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_COUNT (FRAME_COUNT),
    .LINE_ERR    (LINE_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  int compared   = 0;
  int mismatched = 0;
  int n_writes   = 0;
  int exp_writes = 0;
  int done_seen  = 0;

  logic [AW+7:0] exp_q[$];

  // Reference model of the capture sequencer, advanced by the stimulus tasks.
  bit m_busy, m_wait, m_cap, m_err, m_mode;
  int m_y, m_count;

  function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

  // Monitor: every write strobe is matched against the scoreboard queue.
  always @(negedge CLOCK) begin
    logic [AW+7:0] e;
    if (W_EN) begin
      n_writes++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write got addr=%0d data=%02h, expected no write", W_ADDR, W_DATA);
      end else begin
        e = exp_q.pop_front();
        if ({W_ADDR, W_DATA} !== e) begin
          mismatched++;
          $display("FAIL write got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   W_ADDR, W_DATA, e[AW+7:8], e[7:0]);
        end
      end
    end
    if (FRAME_DONE) done_seen++;
  end

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic start_test();
    n_writes   = 0;
    exp_writes = 0;
    done_seen  = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clocks(2);
    RESET = 1'b0;
    exp_q.delete();
    m_busy = 0; m_wait = 0; m_cap = 0; m_err = 0; m_y = 0; m_count = 0;
    clocks(4);
  endtask

  task automatic do_arm();
    ARM = 1'b1;
    clocks(1);
    ARM = 1'b0;
    if (!m_busy) begin
      m_busy = 1; m_wait = 1; m_err = 0;
    end
    clocks(1);
  endtask

  task automatic vsync_low();
    CAM_VSYNC = 1'b0;
    if (m_wait) begin
      m_wait = 0; m_cap = 1; m_y = 0;
    end
    clocks(6);
  endtask

  task automatic vsync_high();
    CAM_VSYNC = 1'b1;
    clocks(8);
    if (m_cap) begin
      m_count = (m_count + 1) % 256;
      if (m_y != H) m_err = 1;
      m_cap = 0;
      if (m_mode) m_busy = 0;
      else m_wait = 1;
    end
  endtask

  // PCLK = CLOCK/4; data is set up while PCLK is low.
  task automatic send_byte(input logic [7:0] b);
    CAM_DATA = b;
    CAM_PCLK = 1'b0;
    clocks(2);
    CAM_PCLK = 1'b1;
    clocks(2);
  endtask

  task automatic send_line(input int n, input int line_no, input int pat);
    int p;
    logic [7:0] hi, lo;
    CAM_HREF = 1'b1;
    for (int i = 0; i < n; i++) begin
      p  = i / 2;
      hi = (pat == 0) ? 8'hE0 : 8'(line_no * W + p * 5 + 1);
      lo = (pat == 0) ? 8'h18 : 8'((p * 3) ^ 8'h5A);
      if (i % 2 == 0) begin
        send_byte(hi);
      end else begin
        if (m_cap) begin
          if (p < W && m_y < H) begin
            exp_q.push_back({AW'(m_y * W + p), rgb332(hi, lo)});
            exp_writes++;
          end else begin
            m_err = 1;
          end
        end
        send_byte(lo);
      end
    end
    CAM_PCLK = 1'b0;
    CAM_HREF = 1'b0;
    if (m_cap) begin
      if (n != 2 * W || m_y >= H) m_err = 1;
      if (m_y < H + 1) m_y++;
    end
    clocks(7);
  endtask

  task automatic frame(input int la, input int na, input int lb, input int nb, input int pat);
    vsync_low();
    for (int l = 0; l < H; l++)
      send_line((l == la) ? na : ((l == lb) ? nb : 2 * W), l, pat);
    vsync_high();
  endtask

  initial begin
    clocks(1);
    do_reset();

    // Reset state
    chk("reset_w_en", W_EN, 0);
    chk("reset_w_addr", W_ADDR, 0);
    chk("reset_w_data", W_DATA, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_frame_done", FRAME_DONE, 0);
    chk("reset_frame_count", FRAME_COUNT, 0);
    chk("reset_line_err", LINE_ERR, 0);

    // Single-shot frame of constant pixels 0xE0/0x18 -> 0xE3
    start_test();
    CAPTURE_MODE = 1'b1; m_mode = 1;
    do_arm();
    chk("armed_busy", BUSY, 1);
    frame(-1, 0, -1, 0, 0);
    chk("single_writes", n_writes, W * H);
    chk("single_model_writes", exp_writes, W * H);
    chk("single_done", done_seen, 1);
    chk("single_count", FRAME_COUNT, 1);
    chk("single_err", LINE_ERR, 0);
    chk("single_busy", BUSY, 0);
    chk("single_last_addr", W_ADDR, W * H - 1);
    chk("single_last_data", W_DATA, 8'hE3);

    // Address order with a distinct pixel value per location
    do_reset();
    start_test();
    do_arm();
    frame(-1, 0, -1, 0, 1);
    chk("order_writes", n_writes, exp_writes);
    chk("order_err", LINE_ERR, 0);

    // Short line 1 (W-1 pixels) and long line 3 (W+4 pixels)
    start_test();
    do_arm();
    frame(1, 2 * W - 2, 3, 2 * W + 8, 1);
    chk("shortlong_writes", n_writes, exp_writes);
    chk("shortlong_model_writes", exp_writes, W * H - 1);
    chk("shortlong_err", LINE_ERR, int'(m_err));
    chk("shortlong_count", FRAME_COUNT, m_count);
    // Idle frame: no writes, error stays sticky
    frame(-1, 0, -1, 0, 0);
    chk("idle_writes", n_writes, exp_writes);
    chk("sticky_err", LINE_ERR, 1);
    do_arm();
    chk("arm_clears_err", LINE_ERR, 0);

    // Continuous mode, armed mid-frame
    do_reset();
    start_test();
    CAPTURE_MODE = 1'b0; m_mode = 0;
    vsync_low();
    send_line(2 * W, 0, 1);
    do_arm();
    send_line(2 * W, 1, 1);
    vsync_high();
    chk("midarm_no_writes", n_writes, 0);
    for (int f = 0; f < 3; f++) frame(-1, 0, -1, 0, 1);
    chk("cont_writes", n_writes, 3 * W * H);
    chk("cont_done", done_seen, 3);
    chk("cont_count", FRAME_COUNT, 3);
    chk("cont_busy", BUSY, 1);

    // Reset in the middle of a frame
    start_test();
    vsync_low();
    for (int l = 0; l < 3; l++) send_line(2 * W, l, 1);
    RESET = 1'b1;
    clocks(1);
    chk("midreset_w_en", W_EN, 0);
    chk("midreset_count", FRAME_COUNT, 0);
    chk("midreset_busy", BUSY, 0);
    RESET = 1'b0;
    m_busy = 0; m_wait = 0; m_cap = 0; m_err = 0; m_count = 0;
    for (int l = 3; l < H; l++) send_line(2 * W, l, 1);
    vsync_high();
    frame(-1, 0, -1, 0, 1);
    chk("midreset_writes", n_writes, 3 * W);
    chk("midreset_model_writes", exp_writes, 3 * W);
    chk("midreset_done", done_seen, 0);

    // Odd byte count on line 2: partial byte dropped, line 3 starts clean
    do_reset();
    start_test();
    CAPTURE_MODE = 1'b1; m_mode = 1;
    do_arm();
    frame(2, 2 * W - 1, -1, 0, 1);
    chk("odd_writes", n_writes, exp_writes);
    chk("odd_model_writes", exp_writes, W * H - 1);
    chk("odd_err", LINE_ERR, 1);
    chk("odd_count", FRAME_COUNT, 1);

    clocks(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
